// File: rtl/edge_detector_bank.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter,
// mode-qualified edge strobes and sticky pending flags with per-channel clear.
module edge_detector_bank #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    localparam int CNT_W      = $clog2(DEBOUNCE + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clear,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   pending,
    output logic                  any_pending
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic [CNT_W-1:0]       cnt_next;
            logic                   level_reg;
            logic                   level_next;
            logic                   pulse_reg;
            logic                   pulse_next;
            logic                   pending_reg;
            logic                   pending_next;
            logic                   s;
            logic                   chg;

            assign s = sync_reg[SYNC_STAGES-1];

            // A change is accepted on the cycle the counter has seen it DEBOUNCE times.
            assign chg = (s != level_reg) && (cnt_reg == CNT_MAX);

            always_comb begin
                cnt_next     = '0;
                level_next   = level_reg;
                pulse_next   = 1'b0;
                if (s == level_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    level_next = s;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                pulse_next   = (chg && s && mode[2*gi]) || (chg && !s && mode[2*gi+1]);
                // A new event wins over a simultaneous clear so nothing is lost.
                pending_next = (pending_reg && !clear[gi]) || pulse_next;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg    <= '0;
                    cnt_reg     <= '0;
                    level_reg   <= 1'b0;
                    pulse_reg   <= 1'b0;
                    pending_reg <= 1'b0;
                end else begin
                    sync_reg    <= {sync_reg[SYNC_STAGES-2:0], in[gi]};
                    cnt_reg     <= cnt_next;
                    level_reg   <= level_next;
                    pulse_reg   <= pulse_next;
                    pending_reg <= pending_next;
                end
            end

            assign level[gi]   = level_reg;
            assign pulse[gi]   = pulse_reg;
            assign pending[gi] = pending_reg;
        end
    endgenerate

    assign any_pending = |pending;

endmodule

// File: doc/edge_detector_bank.md
# edge_detector_bank

Parametrised multi-channel edge detector for the UART front end and its control/status inputs. Each channel synchronises an asynchronous input, rejects glitches with a per-channel debounce counter, and detects rising, falling or both edges according to a runtime mode. Detected edges appear as one-cycle pulses and set sticky pending flags, which are cleared per channel. This block replaces single-channel positive-edge detection wherever more than one line, a falling edge, or noise filtering is needed.

## Interface
- CHANNELS, 4, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- DEBOUNCE, 4, consecutive cycles a changed synchronised value must hold before it is accepted (≥1; 1 = no filtering)
- CNT_W, $clog2(DEBOUNCE+1), debounce counter width (derived, not overridden)

- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- in  in  CHANNELS  asynchronous raw inputs
- mode  in  2*CHANNELS  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- clear  in  CHANNELS  per-channel pending clear, sampled each cycle
- level  out  CHANNELS  debounced, synchronised level
- pulse  out  CHANNELS  one-cycle edge strobe, qualified by mode
- pending  out  CHANNELS  sticky edge flag
- any_pending  out  1  OR of all pending bits (combinational from the pending registers)

## Operation
- Reset (clk edge with reset=1): all synchroniser flops, debounce counters, level, pulse and pending are 0. any_pending is 0. Reset overrides every other input.
- Synchroniser: a SYNC_STAGES-deep shift chain per channel; s = last stage.
- Debounce, per channel, on each edge:
  - If s == level: cnt ← 0.
  - Else if cnt == DEBOUNCE-1: level ← s, cnt ← 0.
  - Else: cnt ← cnt+1.
- Edge qualification: chg = (s != level) && (cnt == DEBOUNCE-1). rise = chg && s; fall = chg && !s.
- Pulse: pulse[i] ← (rise && mode[2i]) || (fall && mode[2i+1]). It is registered on the same edge that updates level, and it is high for exactly one cycle per accepted change.
- Pending: pending[i] ← (pending[i] && !clear[i]) || pulse_next[i].
  - If a set and a clear land on the same edge, the set wins and no event is lost.
  - clear on a channel that is not pending has no effect.
- Mode:
  - Changing mode never disturbs the synchroniser, the debounce counter or level. Only qualification of subsequent edges changes.
  - mode 00 suppresses pulse and new pending sets. Existing pending bits are held until cleared.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse and pending bit.
- Post-reset behaviour: level starts at 0. An input held high through reset produces one rising pulse after the normal latency. This is intended.

## Timing
- Latency: input stable before edge k gives level and pulse updated at edge k+SYNC_STAGES+DEBOUNCE-1. With the defaults that is the 6th edge counting edge k as the 1st.
- Glitch rejection: a value at s lasting fewer than DEBOUNCE cycles never changes level and produces no pulse. Its counter returns to 0 when s reverts.
- Minimum accepted pulse width at the input is DEBOUNCE cycles. Minimum spacing between two reported edges on one channel is DEBOUNCE cycles.
- Pending visibility: a bit sets on the same edge as its pulse and clears on the edge after clear is sampled high. any_pending follows in the same cycle.
- Reset mid-debounce: the counter and level go to 0. The count restarts from scratch after reset deasserts.
- DEBOUNCE=1: level follows s with one cycle of delay. The counter is constant 0.

## Test plan
- Reset with in=0, then in[0] 0→1 held, mode=01, defaults → level[0] and pulse[0] rise exactly 6 edges after the change; pulse is 1 cycle wide; pending[0]=1 and any_pending=1 until clear[0].
- in[1] high for 3 cycles then low, DEBOUNCE=4 → level[1], pulse[1] and pending[1] stay 0 throughout.
- Run mode 01, 10 and 11 on channel 2 with a 1→0 transition → pulse only for 10 and 11; for 01, level still falls and pending stays 0.
- clear[3] asserted on the same edge pending[3] would set → pending[3]=1 afterwards. Then a lone clear[3] → pending[3]=0 on the next edge.
- All four channels toggle together, mode=11 → four simultaneous pulses; clearing channel 0 leaves pending=4'b1110 and any_pending=1.
- reset asserted 2 cycles into a debounce window with in held high → outputs 0 during reset; after release the rising pulse occurs a full 6 edges later.
